// File: rtl/emap_row_scheduler.sv
// emap_row_scheduler: walks rows 0..no_of_rows-1, fetches each row's chunk count, launches the gather unit and tags its output_row stream.
// Latency: out_valid/chunk_last/row_last follow each emap_you_can_read pulse by exactly EMAP_LAT cycles.
// Backpressure: a row is only launched when acc_ready=1; vector writes (wr_req) are granted only in IDLE/ARB with no tags in flight.
//
// Ports: clk/rst_n (rising edge, async active-low reset); start/no_of_rows begin a pass;
//        idx_rd_en/idx_rd_addr/idx_multiples form the index-memory read (data one cycle after the strobe);
//        emap_read_preprocess/emap_you_can_read/emap_write_enable talk to the gather unit; wr_req/wr_gnt arbitrate vector updates;
//        acc_ready is downstream readiness; out_valid/chunk_last/row_last tag the gather output;
//        busy/done/err_clamp report status; perf_busy_cycles/perf_stall_cycles are optional counters.
// Optional feature: define EMAP_SCHED_PERF_EN to build the performance counters (otherwise both read 0).
module emap_row_scheduler #(
    parameter int ROW_W    = 16,
    parameter int MULT_W   = 32,
    parameter int MAX_MULT = 3,
    parameter int EMAP_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ROW_W-1:0]  no_of_rows,
    output logic              idx_rd_en,
    output logic [ROW_W-1:0]  idx_rd_addr,
    input  logic [MULT_W-1:0] idx_multiples,
    output logic              emap_read_preprocess,
    input  logic              emap_you_can_read,
    output logic              emap_write_enable,
    input  logic              wr_req,
    output logic              wr_gnt,
    input  logic              acc_ready,
    output logic              out_valid,
    output logic              chunk_last,
    output logic              row_last,
    output logic              busy,
    output logic              done,
    output logic              err_clamp,
    output logic [31:0]       perf_busy_cycles,
    output logic [31:0]       perf_stall_cycles
);

    typedef enum logic [2:0] {
        IDLE, FETCH, WAIT_IDX, ARB, ISSUE, RUN, DRAIN, DONE
    } state_t;

    localparam logic [MULT_W-1:0] MAX_M = MULT_W'(MAX_MULT);

    state_t            state_q, state_d;
    logic [ROW_W-1:0]  row_cnt_q, row_cnt_d;
    logic [ROW_W-1:0]  rows_q, rows_d;
    logic [MULT_W-1:0] mult_q, mult_d;
    logic [MULT_W-1:0] chunk_cnt_q, chunk_cnt_d;
    logic              err_clamp_q, err_clamp_d;

    // Tag pipe, one entry per cycle of gather latency: {valid, chunk_last, row_last}.
    logic [2:0]        tag_q [EMAP_LAT];

    logic              pipe_empty;
    logic              last_row;
    logic              gnt;
    logic              push;
    logic              push_cl;
    logic              push_rl;

    always_comb begin
        pipe_empty = 1'b1;
        for (int i = 0; i < EMAP_LAT; i++) begin
            if (tag_q[i][2]) pipe_empty = 1'b0;
        end
    end

    // rows_q is never 0 outside IDLE, so rows_q-1 is the index of the final row; wraps cleanly at 2^ROW_W-1 rows.
    assign last_row = (row_cnt_q == rows_q - ROW_W'(1));

    always_comb begin
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        rows_d      = rows_q;
        mult_d      = mult_q;
        chunk_cnt_d = chunk_cnt_q;
        err_clamp_d = err_clamp_q;
        gnt         = 1'b0;
        push        = 1'b0;
        push_cl     = 1'b0;
        push_rl     = 1'b0;
        case (state_q)
            IDLE: begin
                // A pending write beats start; start is simply seen again next cycle if still held.
                if (wr_req) begin
                    gnt = 1'b1;
                end else if (start) begin
                    row_cnt_d   = '0;
                    rows_d      = no_of_rows;
                    err_clamp_d = 1'b0;
                    state_d     = (no_of_rows == '0) ? DONE : FETCH;
                end
            end
            FETCH: state_d = WAIT_IDX;
            WAIT_IDX: begin
                if (idx_multiples > MAX_M) begin
                    mult_d      = MAX_M;
                    err_clamp_d = 1'b1;
                end else begin
                    mult_d = idx_multiples;
                end
                state_d = ARB;
            end
            ARB: begin
                if (wr_req) begin
                    gnt = 1'b1;
                end else if (mult_q == '0) begin
                    row_cnt_d = row_cnt_q + ROW_W'(1);
                    state_d   = last_row ? DONE : FETCH;
                end else if (acc_ready) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                chunk_cnt_d = '0;
                state_d     = RUN;
            end
            RUN: begin
                if (emap_you_can_read) begin
                    push        = 1'b1;
                    push_cl     = (chunk_cnt_q == mult_q - MULT_W'(1));
                    push_rl     = push_cl && last_row;
                    chunk_cnt_d = chunk_cnt_q + MULT_W'(1);
                    if (push_cl) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pipe_empty) begin
                    row_cnt_d = row_cnt_q + ROW_W'(1);
                    state_d   = last_row ? DONE : FETCH;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            row_cnt_q   <= '0;
            rows_q      <= '0;
            mult_q      <= '0;
            chunk_cnt_q <= '0;
            err_clamp_q <= 1'b0;
            for (int i = 0; i < EMAP_LAT; i++) tag_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            rows_q      <= rows_d;
            mult_q      <= mult_d;
            chunk_cnt_q <= chunk_cnt_d;
            err_clamp_q <= err_clamp_d;
            tag_q[0]    <= {push, push_cl, push_rl};
            for (int i = 1; i < EMAP_LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    assign idx_rd_en            = (state_q == FETCH);
    assign idx_rd_addr          = idx_rd_en ? row_cnt_q : '0;
    assign emap_read_preprocess = (state_q == ISSUE);
    // The grant is combinational from wr_req, so it is masked while reset is held to keep all outputs low.
    assign wr_gnt               = gnt & rst_n;
    assign emap_write_enable    = gnt & rst_n;
    assign out_valid            = tag_q[EMAP_LAT-1][2];
    assign chunk_last           = tag_q[EMAP_LAT-1][1];
    assign row_last             = tag_q[EMAP_LAT-1][0];
    assign busy                 = (state_q != IDLE);
    assign done                 = (state_q == DONE);
    assign err_clamp            = err_clamp_q;

`ifdef EMAP_SCHED_PERF_EN
    logic        start_acc;
    logic        stall;
    logic [31:0] perf_busy_q;
    logic [31:0] perf_stall_q;

    assign start_acc = (state_q == IDLE) && start && !wr_req;
    // ARB cycles that do not advance: spent on a write grant, or waiting on the accumulator for a non-empty row.
    assign stall     = (state_q == ARB) && (wr_req || ((mult_q != '0) && !acc_ready));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_busy_q  <= '0;
            perf_stall_q <= '0;
        end else if (start_acc) begin
            perf_busy_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if (busy && (perf_busy_q != '1))   perf_busy_q  <= perf_busy_q + 32'd1;
            if (stall && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_busy_cycles  = perf_busy_q;
    assign perf_stall_cycles = perf_stall_q;
`else
    assign perf_busy_cycles  = '0;
    assign perf_stall_cycles = '0;
`endif

endmodule
